// File: rtl/gcd_engine.sv
// Subtraction-based GCD engine: the IDLE/CALC/DONE FSM drives the ra/rb operand muxes and the result register.
// Optional GCD_ITER_CNT_EN adds an iter_cnt output counting the subtractions in the last transaction.
module gcd_engine #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         in_ready,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef GCD_ITER_CNT_EN
    output logic [W-1:0] iter_cnt,
`endif
    output logic [W-1:0] gcd_out
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] ra_q, ra_d;
    logic [W-1:0] rb_q, rb_d;
    logic [W-1:0] gcd_q, gcd_d;
`ifdef GCD_ITER_CNT_EN
    logic [W-1:0] cnt_q, cnt_d;
`endif

    // Handshake outputs come straight from the state register, with no input paths.
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign gcd_out   = gcd_q;
`ifdef GCD_ITER_CNT_EN
    assign iter_cnt  = cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        gcd_d   = gcd_q;
`ifdef GCD_ITER_CNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d    = a_in;
                    rb_d    = b_in;
`ifdef GCD_ITER_CNT_EN
                    cnt_d   = '0;
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Zero operands terminate immediately so the engine never spins on them.
                if (ra_q == '0) begin
                    gcd_d   = rb_q;
                    state_d = S_DONE;
                end else if ((rb_q == '0) || (ra_q == rb_q)) begin
                    gcd_d   = ra_q;
                    state_d = S_DONE;
                end else if (ra_q > rb_q) begin
                    ra_d    = ra_q - rb_q;
`ifdef GCD_ITER_CNT_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                end else begin
                    rb_d    = rb_q - ra_q;
`ifdef GCD_ITER_CNT_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            gcd_q   <= '0;
`ifdef GCD_ITER_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            gcd_q   <= gcd_d;
`ifdef GCD_ITER_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: the driver pushes expected {gcd, k, accept cycle}, the monitor pops on out_valid rise.
module tb_gcd_engine;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         in_ready, busy, out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] gcd_out;
`ifdef GCD_ITER_CNT_EN
    logic [W-1:0] iter_cnt;
`endif

    gcd_engine #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .in_ready(in_ready), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
`ifdef GCD_ITER_CNT_EN
        .iter_cnt(iter_cnt),
`endif
        .gcd_out(gcd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int g;
        int k;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_v = 1'b0;
    logic have_cur = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_g(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int ref_k(input int a, input int b);
        int k = 0;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) a -= b;
            else       b -= a;
            k++;
        end
        return k;
    endfunction

    // Monitor: new result on out_valid rise, then stability while it stays high.
    always @(negedge clk) begin
        if (!rst && out_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
                have_cur = 1'b0;
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                chk("gcd_out", int'(gcd_out), cur.g);
                chk("latency", cyc - cur.acc, cur.k + 1);
`ifdef GCD_ITER_CNT_EN
                chk("iter_cnt", int'(iter_cnt), cur.k);
`endif
            end
        end else if (!rst && out_valid && have_cur) begin
            chk("gcd_hold", int'(gcd_out), cur.g);
        end
        prev_v = out_valid;
    end

    task automatic send(input int a, input int b, input int g, input int k);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        start = 1'b1;
        a_in  = W'(a);
        b_in  = W'(b);
        @(posedge clk);
        #1;
        exp_q.push_back('{g: g, k: k, acc: cyc});
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    int perm[256];

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_gcd_out", int'(gcd_out), 0);
`ifdef GCD_ITER_CNT_EN
        chk("rst_iter_cnt", int'(iter_cnt), 0);
`endif
        rst = 1'b0;

        send(12, 8, 4, 2);
        send(15, 1, 1, 14);
        send(0, 9, 9, 0);
        send(9, 0, 9, 0);
        send(0, 0, 0, 0);
        send(7, 7, 7, 0);
        drain();

        // Back-pressure: result held, stray starts ignored.
        out_ready = 1'b0;
        send(6, 4, 2, 2);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("bp_valid_timeout", int'(out_valid), 1);
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_busy", int'(busy), 1);
            start = 1'b1;
            a_in  = 4'd3;
            b_in  = 4'd3;
        end
        @(negedge clk);
        start = 1'b0;
        chk("bp_still_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_no_stray", exp_q.size(), 0);

        // Reset mid-CALC discards the transaction.
        send(15, 1, 1, 14);
        repeat (4) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_in_ready", int'(in_ready), 1);
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_gcd_out", int'(gcd_out), 0);
        send(9, 6, 3, 2);
        drain();

        // All 256 pairs, shuffled, back-to-back.
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            int a, b;
            a = perm[i] / 16;
            b = perm[i] % 16;
            send(a, b, ref_g(a, b), ref_k(a, b));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
